// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port to one-port line memory arbiter:
// LC-3b word/line widths, arbiter state encoding and the line-alignment helper.
package mem_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    localparam lc3b_word LINE_OFFSET_MASK = 16'h000F;

    // Lines are 16 bytes, so the downstream port only ever sees line-aligned addresses.
    function automatic lc3b_word line_align(input lc3b_word addr);
        return addr & ~LINE_OFFSET_MASK;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and physical-memory line ports around the arbiter.
// Handshake: a requester holds read/write (and address/data) until its one-cycle resp pulse.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic     i_read;
    lc3b_word i_address;
    lc3b_line i_rdata;
    logic     i_resp;

    logic     d_read;
    logic     d_write;
    lc3b_word d_address;
    lc3b_line d_wdata;
    lc3b_line d_rdata;
    logic     d_resp;

    logic     pmem_read;
    logic     pmem_write;
    lc3b_word pmem_address;
    lc3b_line pmem_wdata;
    lc3b_line pmem_rdata;
    logic     pmem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
        input  pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
        output pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting the split L1 caches one at a time onto a single line-wide
// memory port; the winning request is latched so the downstream side sees stable signals.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  io_bus,
    output arb_state_t    o_state,
    output logic          o_last_d
);

    arb_state_t r_state;
    logic       r_last_d;
    logic       r_pmem_read;
    logic       r_pmem_write;
    lc3b_word   r_pmem_address;
    lc3b_line   r_pmem_wdata;

    logic       w_req_i;
    logic       w_req_d;
    logic       w_grant_d;

    assign w_req_i = io_bus.i_read;
    assign w_req_d = io_bus.d_read | io_bus.d_write;
    // On contention, the port that was not served last wins.
    assign w_grant_d = w_req_d & (~w_req_i | ~r_last_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_last_d       <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state        <= SERVE_D;
                        r_last_d       <= 1'b1;
                        // read+write together is treated as a writeback
                        r_pmem_read    <= ~io_bus.d_write;
                        r_pmem_write   <= io_bus.d_write;
                        r_pmem_address <= line_align(io_bus.d_address);
                        r_pmem_wdata   <= io_bus.d_wdata;
                    end else if (w_req_i) begin
                        r_state        <= SERVE_I;
                        r_last_d       <= 1'b0;
                        r_pmem_read    <= 1'b1;
                        r_pmem_write   <= 1'b0;
                        r_pmem_address <= line_align(io_bus.i_address);
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (io_bus.pmem_resp) begin
                        r_state      <= IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.pmem_read    = r_pmem_read;
    assign io_bus.pmem_write   = r_pmem_write;
    assign io_bus.pmem_address = r_pmem_address;
    assign io_bus.pmem_wdata   = r_pmem_wdata;

    // Completion is forwarded in the same cycle, only to the port currently granted.
    assign io_bus.i_resp  = (r_state == SERVE_I) & io_bus.pmem_resp;
    assign io_bus.d_resp  = (r_state == SERVE_D) & io_bus.pmem_resp;
    assign io_bus.i_rdata = io_bus.pmem_rdata;
    assign io_bus.d_rdata = io_bus.pmem_rdata;

    assign o_state  = r_state;
    assign o_last_d = r_last_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected pmem commands and cache responses are queued
// by the stimulus and checked by independent monitors on the falling clock edge.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic       clk;
    logic       reset;
    arb_state_t o_state;
    logic       o_last_d;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .io_bus   (bus),
        .o_state  (o_state),
        .o_last_d (o_last_d)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // {read, write, address, wdata}
    logic [145:0] cmd_q[$];
    // {is_d, rdata}
    logic [128:0] resp_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    logic prev_cmd = 1'b0;

    always @(negedge clk) begin
        logic         cmd_now;
        logic [145:0] e;
        cmd_now = bus.pmem_read | bus.pmem_write;
        if (cmd_now && !prev_cmd) begin
            if (cmd_q.size() == 0) begin
                chk("cmd_unexpected", cmd_now, 1'b0);
            end else begin
                e = cmd_q.pop_front();
                chk("cmd_op", {bus.pmem_read, bus.pmem_write}, e[145:144]);
                chk("cmd_addr", bus.pmem_address, e[143:128]);
                if (e[144]) chk("cmd_wdata", bus.pmem_wdata, e[127:0]);
            end
        end
        prev_cmd = cmd_now;
    end

    always @(negedge clk) begin
        logic [128:0] e;
        if (bus.i_resp || bus.d_resp) begin
            chk("resp_both", bus.i_resp & bus.d_resp, 1'b0);
            if (resp_q.size() == 0) begin
                chk("resp_unexpected", {bus.i_resp, bus.d_resp}, 2'b00);
            end else begin
                e = resp_q.pop_front();
                chk("resp_port", {bus.d_resp, bus.i_resp}, e[128] ? 2'b10 : 2'b01);
                chk("resp_rdata", e[128] ? bus.d_rdata : bus.i_rdata, e[127:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Counts falling edges until a pmem command is visible (bounded).
    task automatic wait_cmd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.pmem_read | bus.pmem_write) && n < 20);
        chk("cmd_timeout", bus.pmem_read | bus.pmem_write, 1'b1);
    endtask

    task automatic pmem_respond(input lc3b_line data, input int delay);
        repeat (delay) @(posedge clk);
        #1;
        bus.pmem_rdata = data;
        bus.pmem_resp  = 1'b1;
        @(posedge clk);
        #1;
        bus.pmem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    lc3b_word d_tab[4] = '{16'h2008, 16'h2018, 16'h2028, 16'h2038};
    lc3b_word i_tab[4] = '{16'h3004, 16'h3014, 16'h3024, 16'h3034};

    initial begin
        int       n;
        lc3b_line data;
        int       di;
        int       ii;

        reset          = 1'b1;
        bus.i_read     = 1'b0;
        bus.i_address  = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_address  = '0;
        bus.d_wdata    = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", o_state, IDLE);
        chk("rst_last_d", o_last_d, 1'b0);
        chk("rst_pmem_read", bus.pmem_read, 1'b0);
        chk("rst_pmem_write", bus.pmem_write, 1'b0);
        chk("rst_pmem_address", bus.pmem_address, 16'h0);
        chk("rst_pmem_wdata", bus.pmem_wdata, 128'h0);
        chk("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        @(posedge clk);
        #1 reset = 1'b0;

        // I-only read: command one cycle after the request is first seen.
        @(posedge clk);
        #1;
        bus.i_read    = 1'b1;
        bus.i_address = 16'h1234;
        data = {32{4'hA}};
        cmd_q.push_back({1'b1, 1'b0, 16'h1230, 128'h0});
        resp_q.push_back({1'b0, data});
        wait_cmd(n);
        chk("i_grant_latency", n, 2);
        chk("i_state", o_state, SERVE_I);
        pmem_respond(data, 2);
        bus.i_read = 1'b0;

        // D writeback.
        @(posedge clk);
        #1;
        bus.d_write   = 1'b1;
        bus.d_address = 16'h8000;
        bus.d_wdata   = {32{4'h5}};
        data = {32{4'h3}};
        cmd_q.push_back({1'b0, 1'b1, 16'h8000, {32{4'h5}}});
        resp_q.push_back({1'b1, data});
        wait_cmd(n);
        chk("d_state", o_state, SERVE_D);
        pmem_respond(data, 3);
        bus.d_write = 1'b0;

        // Simultaneous requests after reset: D first, then I two cycles after the resp.
        do_reset();
        #1;
        bus.d_read    = 1'b1;
        bus.d_address = 16'h6001;
        bus.i_read    = 1'b1;
        bus.i_address = 16'h700F;
        data = {4{32'h1111_2222}};
        cmd_q.push_back({1'b1, 1'b0, 16'h6000, 128'h0});
        resp_q.push_back({1'b1, data});
        wait_cmd(n);
        chk("both_first_d", o_state, SERVE_D);
        pmem_respond(data, 1);
        bus.d_read = 1'b0;
        data = {4{32'h3333_4444}};
        cmd_q.push_back({1'b1, 1'b0, 16'h7000, 128'h0});
        resp_q.push_back({1'b0, data});
        wait_cmd(n);
        chk("b2b_latency", n, 2);
        chk("both_then_i", o_state, SERVE_I);
        pmem_respond(data, 1);
        bus.i_read = 1'b0;

        // Continuous contention: grants alternate D, I, D, I.
        @(posedge clk);
        #1;
        di = 0;
        ii = 0;
        bus.d_read    = 1'b1;
        bus.d_address = d_tab[0];
        bus.i_read    = 1'b1;
        bus.i_address = i_tab[0];
        for (int t = 0; t < 4; t++) begin
            data = {4{32'hC0DE_0000 + t}};
            if (t % 2 == 0) begin
                cmd_q.push_back({1'b1, 1'b0, line_align(d_tab[di]), 128'h0});
                resp_q.push_back({1'b1, data});
            end else begin
                cmd_q.push_back({1'b1, 1'b0, line_align(i_tab[ii]), 128'h0});
                resp_q.push_back({1'b0, data});
            end
            wait_cmd(n);
            chk("rr_latency", n, 2);
            chk("rr_grant", o_state, (t % 2 == 0) ? SERVE_D : SERVE_I);
            pmem_respond(data, 1 + t);
            if (t % 2 == 0) begin
                di++;
                bus.d_address = d_tab[di];
            end else begin
                ii++;
                bus.i_address = i_tab[ii];
            end
        end
        bus.d_read = 1'b0;
        bus.i_read = 1'b0;

        // Requester address changes while served; the latched address must hold.
        @(posedge clk);
        #1;
        bus.d_read    = 1'b1;
        bus.d_address = 16'h4567;
        data = {4{32'hDEAD_BEEF}};
        cmd_q.push_back({1'b1, 1'b0, 16'h4560, 128'h0});
        resp_q.push_back({1'b1, data});
        wait_cmd(n);
        bus.d_address = 16'h9999;
        bus.d_wdata   = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("addr_hold", bus.pmem_address, 16'h4560);
            chk("read_hold", {bus.pmem_read, bus.pmem_write}, 2'b10);
        end
        pmem_respond(data, 1);
        bus.d_read = 1'b0;

        // Asynchronous reset while serving I drops the command; a late resp is swallowed.
        @(posedge clk);
        #1;
        bus.i_read    = 1'b1;
        bus.i_address = 16'hABCD;
        cmd_q.push_back({1'b1, 1'b0, 16'hABC0, 128'h0});
        wait_cmd(n);
        chk("pre_reset_state", o_state, SERVE_I);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_read", bus.pmem_read, 1'b0);
        chk("async_rst_state", o_state, IDLE);
        @(posedge clk);
        #1 bus.i_read = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        bus.pmem_rdata = {4{32'hFEED_F00D}};
        bus.pmem_resp  = 1'b1;
        @(negedge clk);
        chk("idle_resp_ignored", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("idle_no_cmd", {bus.pmem_read, bus.pmem_write}, 2'b00);
        @(posedge clk);
        #1 bus.pmem_resp = 1'b0;

        // Drain and confirm every expected transaction was observed.
        for (int k = 0; k < 20 && (cmd_q.size() != 0 || resp_q.size() != 0); k++)
            @(negedge clk);
        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
